// File: rtl/axis_lite_pattern_gen_pkg.sv
// Shared definitions for the Lite-programmed stream pattern generator:
// register map, CTRL bit positions, response codes and stream FSM states.
package axis_lite_pattern_gen_pkg;

    localparam int unsigned OFF_CTRL   = 32'h00;
    localparam int unsigned OFF_LEN    = 32'h04;
    localparam int unsigned OFF_STATUS = 32'h08;
    localparam int unsigned OFF_SEED   = 32'h0C;
    localparam int unsigned OFF_IDDEST = 32'h10;
    localparam int unsigned OFF_DREG0  = 32'h40;

    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_LOOP  = 2;
    localparam int CTRL_ABORT = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_lite_pattern_regs.sv
// AXI4-Lite slave and register file for the pattern generator; exports the
// configuration plus START/ABORT pulses and reads back the stream status.
module axis_lite_pattern_regs
    import axis_lite_pattern_gen_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_DATA_REGS      = 8,
    parameter int C_AXIS_ID_WIDTH    = 8,
    parameter int C_AXIS_DEST_WIDTH  = 4,
    parameter int LEN_WIDTH          = 16,
    localparam int DIDX_W = (NUM_DATA_REGS > 1) ? $clog2(NUM_DATA_REGS) : 1
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    input  logic                          busy_i,
    input  logic                          done_i,
    input  logic [LEN_WIDTH-1:0]          beat_cnt_i,
    input  logic [DIDX_W-1:0]             dreg_sel_i,
    output logic                          mode_o,
    output logic                          loop_o,
    output logic                          start_o,
    output logic                          abort_o,
    output logic [LEN_WIDTH-1:0]          len_o,
    output logic [31:0]                   seed_o,
    output logic [C_AXIS_ID_WIDTH-1:0]    tid_o,
    output logic [C_AXIS_DEST_WIDTH-1:0]  tdest_o,
    output logic [31:0]                   dreg_data_o
);

    logic                         awready_q, arready_q, bvalid_q, rvalid_q;
    logic [1:0]                   bresp_q, rresp_q;
    logic [31:0]                  rdata_q;
    logic                         mode_q, loop_q;
    logic [LEN_WIDTH-1:0]         len_q;
    logic [31:0]                  seed_q;
    logic [C_AXIS_ID_WIDTH-1:0]   tid_q;
    logic [C_AXIS_DEST_WIDTH-1:0] tdest_q;
    logic [31:0]                  dreg_q [NUM_DATA_REGS];

    logic        wr_hs, rd_hs, wr_ok, wr_err, rd_err, wr_ctrl;
    logic [31:0] wword, rword, rd_data, iddest_rd, iddest_wr, ctrl_rd;
    logic        unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    assign wr_hs     = awready_q & s_axi_awvalid & s_axi_wvalid;
    assign rd_hs     = arready_q & s_axi_arvalid;
    assign wword     = 32'(s_axi_awaddr) >> 2;
    assign rword     = 32'(s_axi_araddr) >> 2;
    assign wr_ok     = wr_hs & ~wr_err;
    assign wr_ctrl   = wr_ok & (wword == (OFF_CTRL >> 2)) & s_axi_wstrb[0];
    assign iddest_rd = 32'(tid_q) | (32'(tdest_q) << 8);
    assign iddest_wr = wstrb_merge(iddest_rd, s_axi_wdata, s_axi_wstrb);
    assign ctrl_rd   = (32'(loop_q) << CTRL_LOOP) | (32'(mode_q) << CTRL_MODE);

    // LOOP and ABORT stay writable mid-packet; only a MODE change is refused.
    always_comb begin
        wr_err = 1'b0;
        if (wword == (OFF_CTRL >> 2))
            wr_err = busy_i & s_axi_wstrb[0] & (s_axi_wdata[CTRL_MODE] != mode_q);
        else if (wword == (OFF_LEN >> 2) || wword == (OFF_SEED >> 2) ||
                 wword == (OFF_IDDEST >> 2))
            wr_err = busy_i;
        else if (wword >= (OFF_DREG0 >> 2) &&
                 wword < (OFF_DREG0 >> 2) + 32'(NUM_DATA_REGS))
            wr_err = busy_i;
        else
            wr_err = 1'b1;
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (rword == (OFF_CTRL >> 2))        rd_data = ctrl_rd;
        else if (rword == (OFF_LEN >> 2))    rd_data = 32'(len_q);
        else if (rword == (OFF_STATUS >> 2)) rd_data = {16'(beat_cnt_i), 14'd0, done_i, busy_i};
        else if (rword == (OFF_SEED >> 2))   rd_data = seed_q;
        else if (rword == (OFF_IDDEST >> 2)) rd_data = iddest_rd;
        else if (rword >= (OFF_DREG0 >> 2) &&
                 rword < (OFF_DREG0 >> 2) + 32'(NUM_DATA_REGS)) begin
            for (int k = 0; k < NUM_DATA_REGS; k++) begin
                if (rword == (OFF_DREG0 >> 2) + 32'(k)) rd_data = dreg_q[k];
            end
        end
        else rd_err = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            mode_q    <= 1'b0;
            loop_q    <= 1'b0;
            len_q     <= '0;
            seed_q    <= '0;
            tid_q     <= '0;
            tdest_q   <= '0;
            for (int k = 0; k < NUM_DATA_REGS; k++) dreg_q[k] <= '0;
        end else begin
            awready_q <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
            arready_q <= s_axi_arvalid & ~rvalid_q & ~arready_q;

            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end

            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_err ? 32'd0 : rd_data;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end

            if (wr_ctrl) begin
                mode_q <= s_axi_wdata[CTRL_MODE];
                loop_q <= s_axi_wdata[CTRL_LOOP];
            end
            if (wr_ok) begin
                if (wword == (OFF_LEN >> 2))
                    len_q <= LEN_WIDTH'(wstrb_merge(32'(len_q), s_axi_wdata, s_axi_wstrb));
                if (wword == (OFF_SEED >> 2))
                    seed_q <= wstrb_merge(seed_q, s_axi_wdata, s_axi_wstrb);
                if (wword == (OFF_IDDEST >> 2)) begin
                    tid_q   <= C_AXIS_ID_WIDTH'(iddest_wr[7:0]);
                    tdest_q <= C_AXIS_DEST_WIDTH'(iddest_wr[11:8]);
                end
                for (int k = 0; k < NUM_DATA_REGS; k++) begin
                    if (wword == (OFF_DREG0 >> 2) + 32'(k))
                        dreg_q[k] <= wstrb_merge(dreg_q[k], s_axi_wdata, s_axi_wstrb);
                end
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    assign start_o     = wr_ctrl & s_axi_wdata[CTRL_START];
    assign abort_o     = wr_ctrl & s_axi_wdata[CTRL_ABORT];
    assign mode_o      = mode_q;
    assign loop_o      = loop_q;
    assign len_o       = len_q;
    assign seed_o      = seed_q;
    assign tid_o       = tid_q;
    assign tdest_o     = tdest_q;
    assign dreg_data_o = dreg_q[dreg_sel_i];

endmodule

// File: rtl/axis_lite_pattern_gen.sv
// Lite-programmed AXI4-Stream packet generator: register file plus stream FSM.
//   state   | meaning
//   ST_IDLE | no packet in flight, TVALID low, waiting for START
//   ST_RUN  | TVALID high, emitting beats until TLAST handshake (looping if LOOP)
module axis_lite_pattern_gen
    import axis_lite_pattern_gen_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_DATA_REGS      = 8,
    parameter int C_AXIS_ID_WIDTH    = 8,
    parameter int C_AXIS_DEST_WIDTH  = 4,
    parameter int LEN_WIDTH          = 16,
    localparam int DIDX_W = (NUM_DATA_REGS > 1) ? $clog2(NUM_DATA_REGS) : 1
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [31:0]                   m_axis_tdata,
    output logic [3:0]                    m_axis_tstrb,
    output logic [3:0]                    m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [C_AXIS_ID_WIDTH-1:0]    m_axis_tid,
    output logic [C_AXIS_DEST_WIDTH-1:0]  m_axis_tdest
);

    logic                 mode, loop_en, start_p, abort_p;
    logic [LEN_WIDTH-1:0] len_cfg;
    logic [31:0]          seed, dreg_data;

    state_t               state_q;
    logic [LEN_WIDTH-1:0] beat_q;
    logic [DIDX_W-1:0]    didx_q;
    logic                 tvalid_q, done_q, abort_pend_q;
    logic                 hs, tlast;

    axis_lite_pattern_regs #(
        .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .NUM_DATA_REGS      (NUM_DATA_REGS),
        .C_AXIS_ID_WIDTH    (C_AXIS_ID_WIDTH),
        .C_AXIS_DEST_WIDTH  (C_AXIS_DEST_WIDTH),
        .LEN_WIDTH          (LEN_WIDTH)
    ) u_regs (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .busy_i        (state_q == ST_RUN),
        .done_i        (done_q),
        .beat_cnt_i    (beat_q),
        .dreg_sel_i    (didx_q),
        .mode_o        (mode),
        .loop_o        (loop_en),
        .start_o       (start_p),
        .abort_o       (abort_p),
        .len_o         (len_cfg),
        .seed_o        (seed),
        .tid_o         (m_axis_tid),
        .tdest_o       (m_axis_tdest),
        .dreg_data_o   (dreg_data)
    );

    // Config is write-protected while running, so these stay stable across stalls.
    assign hs    = tvalid_q & m_axis_tready;
    assign tlast = abort_pend_q | (beat_q == len_cfg - LEN_WIDTH'(1));

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            didx_q       <= '0;
            tvalid_q     <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_p) begin
                        if (len_cfg != '0) begin
                            state_q      <= ST_RUN;
                            tvalid_q     <= 1'b1;
                            beat_q       <= '0;
                            didx_q       <= '0;
                            done_q       <= 1'b0;
                            abort_pend_q <= 1'b0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort_p) abort_pend_q <= 1'b1;
                    if (hs) begin
                        beat_q <= beat_q + 1'b1;
                        didx_q <= (didx_q == DIDX_W'(NUM_DATA_REGS - 1)) ? '0 : didx_q + 1'b1;
                        if (tlast) begin
                            if (loop_en && !abort_pend_q) begin
                                beat_q <= '0;
                                didx_q <= '0;
                            end else begin
                                state_q      <= ST_IDLE;
                                tvalid_q     <= 1'b0;
                                done_q       <= 1'b1;
                                abort_pend_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = mode ? seed + 32'(beat_q) : dreg_data;
    assign m_axis_tlast  = tvalid_q & tlast;
    assign m_axis_tstrb  = 4'hF;
    assign m_axis_tkeep  = 4'hF;

endmodule

// File: tb/tb_axis_lite_pattern_gen.sv
// Directed bench for axis_lite_pattern_gen: Lite register access, replay and
// counter packets, loop/abort, error responses and reset behaviour.
module tb_axis_lite_pattern_gen;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK, ARESETN;
    logic [7:0]  s_axi_awaddr, s_axi_araddr;
    logic [2:0]  s_axi_awprot, s_axi_arprot;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tstrb, m_axis_tkeep;
    logic [7:0]  m_axis_tid;
    logic [3:0]  m_axis_tdest;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] data_q [$];
    logic        last_q [$];
    int          tv_seen    = 0;
    int          rdy_limit  = 1000;
    bit          rdy_toggle = 0;
    bit          stall_prev = 0;
    logic [31:0] stall_data = '0;

    logic [31:0] dv [8] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011,
                            32'h44440004, 32'h55550005, 32'h66660006, 32'h77770007};
    logic [31:0] cnt_exp [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    logic [31:0] loop_exp [5] = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1};
    logic        loop_last [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    axis_lite_pattern_gen dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Stream sink: records beats that will handshake at the next rising edge.
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETN) begin
                if (m_axis_tvalid) tv_seen++;
                if (stall_prev && m_axis_tvalid) check_val("tdata_stable", m_axis_tdata, stall_data);
                stall_prev = m_axis_tvalid & ~m_axis_tready;
                stall_data = m_axis_tdata;
                if (m_axis_tvalid && m_axis_tready) begin
                    data_q.push_back(m_axis_tdata);
                    last_q.push_back(m_axis_tlast);
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            if (rdy_toggle) m_axis_tready = ~m_axis_tready;
            else            m_axis_tready = (data_q.size() < rdy_limit);
        end
    end

    task automatic axil_write(input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!s_axi_awready && n < 20);
        check_val("awready", 32'(s_axi_awready), 32'd1);
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(negedge ACLK); n++; end
        check_val("bvalid", 32'(s_axi_bvalid), 32'd1);
        resp = s_axi_bresp;
        @(negedge ACLK);
        s_axi_bready = 1'b0;
    endtask

    task automatic axil_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!s_axi_arready && n < 20);
        check_val("arready", 32'(s_axi_arready), 32'd1);
        @(negedge ACLK);
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin @(negedge ACLK); n++; end
        check_val("rvalid", 32'(s_axi_rvalid), 32'd1);
        d = s_axi_rdata; resp = s_axi_rresp;
        @(negedge ACLK);
        s_axi_rready = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] d,
                          input logic [1:0] exp_resp);
        logic [1:0] r;
        axil_write(a, d, 4'hF, r);
        check_val({tag, "_bresp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axil_read(a, d, r);
        check_val({tag, "_rdata"}, d, exp_d);
        check_val({tag, "_rresp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (data_q.size() < n && c < 500) begin @(negedge ACLK); c++; end
        check_val("beat_count", 32'(data_q.size()), 32'(n));
    endtask

    task automatic clear_sink();
        data_q.delete();
        last_q.delete();
    endtask

    initial begin
        logic [1:0] r;
        int         nl;
        ARESETN = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        repeat (4) @(negedge ACLK);
        check_val("rst_awready", 32'(s_axi_awready), 32'd0);
        check_val("rst_wready",  32'(s_axi_wready),  32'd0);
        check_val("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check_val("rst_arready", 32'(s_axi_arready), 32'd0);
        check_val("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check_val("rst_rdata",   s_axi_rdata,        32'd0);
        check_val("rst_tvalid",  32'(m_axis_tvalid), 32'd0);
        ARESETN = 1'b1;

        for (int k = 0; k < 8; k++) wr_chk("dreg_wr", 8'h40 + 8'(4*k), dv[k], OKAY);
        for (int k = 0; k < 8; k++) rd_chk("dreg_rd", 8'h40 + 8'(4*k), dv[k], OKAY);
        axil_write(8'h5C, 32'h12345678, 4'b0011, r);
        check_val("dreg7_strb_bresp", 32'(r), 32'(OKAY));
        rd_chk("dreg7_strb", 8'h5C, 32'h77775678, OKAY);
        wr_chk("iddest_wr", 8'h10, 32'hFFFFFA5C, OKAY);
        rd_chk("iddest_rd", 8'h10, 32'h00000A5C, OKAY);
        check_val("tid", 32'(m_axis_tid), 32'h5C);
        check_val("tdest", 32'(m_axis_tdest), 32'hA);
        check_val("tstrb", 32'(m_axis_tstrb), 32'hF);
        check_val("tkeep", 32'(m_axis_tkeep), 32'hF);

        // Replay mode, six beats from DREG0..5
        wr_chk("len6", 8'h04, 32'd6, OKAY);
        clear_sink();
        wr_chk("start_replay", 8'h00, 32'h1, OKAY);
        wait_beats(6);
        repeat (3) @(negedge ACLK);
        for (int i = 0; i < 6; i++) begin
            check_val("replay_data", data_q[i], dv[i]);
            check_val("replay_last", 32'(last_q[i]), 32'(i == 5));
        end
        check_val("replay_tvalid_end", 32'(m_axis_tvalid), 32'd0);
        rd_chk("replay_status", 8'h08, 32'h00060002, OKAY);

        // Counter mode wrapping through zero under back-pressure
        wr_chk("seed", 8'h0C, 32'hFFFFFFFE, OKAY);
        wr_chk("len4", 8'h04, 32'd4, OKAY);
        clear_sink();
        rdy_toggle = 1'b1;
        wr_chk("start_cnt", 8'h00, 32'h3, OKAY);
        wait_beats(4);
        repeat (3) @(negedge ACLK);
        rdy_toggle = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("cnt_data", data_q[i], cnt_exp[i]);
            check_val("cnt_last", 32'(last_q[i]), 32'(i == 3));
        end

        // Loop, then abort while stalled on the fifth beat
        wr_chk("seed0", 8'h0C, 32'd0, OKAY);
        wr_chk("len3", 8'h04, 32'd3, OKAY);
        clear_sink();
        rdy_limit = 4;
        wr_chk("start_loop", 8'h00, 32'h7, OKAY);
        wait_beats(4);
        repeat (3) @(negedge ACLK);
        check_val("loop_stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        rd_chk("loop_status", 8'h08, 32'h00010001, OKAY);
        wr_chk("len_busy", 8'h04, 32'd9, SLVERR);
        rd_chk("len_kept", 8'h04, 32'd3, OKAY);
        wr_chk("start_busy", 8'h00, 32'h7, OKAY);
        wr_chk("abort", 8'h00, 32'hE, OKAY);
        rdy_limit = 1000;
        wait_beats(5);
        repeat (3) @(negedge ACLK);
        for (int i = 0; i < 5; i++) begin
            check_val("loop_data", data_q[i], loop_exp[i]);
            check_val("loop_last", 32'(last_q[i]), 32'(loop_last[i]));
        end
        check_val("abort_tvalid_end", 32'(m_axis_tvalid), 32'd0);
        rd_chk("abort_status", 8'h08, 32'h00020002, OKAY);
        rd_chk("ctrl_rd", 8'h00, 32'h6, OKAY);

        // Error responses
        rd_chk("unmapped_rd", 8'h20, 32'd0, SLVERR);
        wr_chk("unmapped_wr", 8'h20, 32'h1234, SLVERR);
        wr_chk("status_wr", 8'h08, 32'hFFFF, SLVERR);
        rd_chk("dreg_oor_rd", 8'h60, 32'd0, SLVERR);

        // ABORT while idle does nothing
        tv_seen = 0;
        wr_chk("abort_idle", 8'h00, 32'h8, OKAY);
        repeat (5) @(negedge ACLK);
        check_val("abort_idle_tvalid", 32'(tv_seen), 32'd0);
        rd_chk("ctrl_cleared", 8'h00, 32'd0, OKAY);

        // Reset in the middle of a long packet
        wr_chk("len100", 8'h04, 32'd100, OKAY);
        clear_sink();
        wr_chk("start_long", 8'h00, 32'h3, OKAY);
        wait_beats(3);
        @(negedge ACLK);
        ARESETN = 1'b0;
        @(negedge ACLK);
        check_val("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        nl = 0;
        foreach (last_q[i]) if (last_q[i]) nl++;
        check_val("rst_mid_no_tlast", 32'(nl), 32'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        rd_chk("post_rst_ctrl",   8'h00, 32'd0, OKAY);
        rd_chk("post_rst_len",    8'h04, 32'd0, OKAY);
        rd_chk("post_rst_status", 8'h08, 32'd0, OKAY);
        rd_chk("post_rst_seed",   8'h0C, 32'd0, OKAY);
        rd_chk("post_rst_iddest", 8'h10, 32'd0, OKAY);
        rd_chk("post_rst_dreg0",  8'h40, 32'd0, OKAY);
        check_val("post_rst_tid", 32'(m_axis_tid), 32'd0);

        // START with LEN=0 only sets DONE
        tv_seen = 0;
        wr_chk("start_len0", 8'h00, 32'h1, OKAY);
        repeat (10) @(negedge ACLK);
        check_val("len0_tvalid", 32'(tv_seen), 32'd0);
        rd_chk("len0_status", 8'h08, 32'h00000002, OKAY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_lite_pattern_gen.md
Name: axis_lite_pattern_gen

Overview:
- AXI4-Lite-programmed AXI4-Stream packet generator, next generation of the team's lite-register/stream test IP.
- A Lite master (BFM or PS) loads a data register file and control registers, then starts a packet.
- The block emits LEN beats on an AXI4-Stream master, either replaying the register file or generating an incrementing counter, with TLAST, programmable TID/TDEST, loop and abort.
- Sits between the Lite master BFM and the streaming slave BFM in the test block design.

Parameters:
- C_S_AXI_ADDR_WIDTH, 8, Lite address width; register decode uses bits [C_S_AXI_ADDR_WIDTH-1:2].
- NUM_DATA_REGS, 8, data register count (1..48); power of two not required.
- C_AXIS_ID_WIDTH, 8, TID width.
- C_AXIS_DEST_WIDTH, 4, TDEST width.
- LEN_WIDTH, 16, packet length counter width.

Ports:
- ACLK in 1: single clock.
- ARESETN in 1: synchronous, active-low reset.
- s_axi_awaddr in C_S_AXI_ADDR_WIDTH; s_axi_awprot in 3 (ignored); s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata in 32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_araddr in C_S_AXI_ADDR_WIDTH; s_axi_arprot in 3 (ignored); s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rdata out 32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
- m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tdata out 32; m_axis_tstrb out 4; m_axis_tkeep out 4.
- m_axis_tlast out 1; m_axis_tid out C_AXIS_ID_WIDTH; m_axis_tdest out C_AXIS_DEST_WIDTH.

Behaviour:
- Reset (ARESETN=0 at ACLK edge): all ready/valid outputs 0, resp 0, rdata 0, all registers 0, FSM IDLE. Reset mid-packet drops TVALID next cycle; no TLAST is sent.
- Register map:
  - 0x00 CTRL (W): [0] START (self-clearing), [1] MODE (0=replay, 1=counter), [2] LOOP, [3] ABORT (self-clearing). Reads return MODE and LOOP; START and ABORT read 0.
  - 0x04 LEN (RW, LEN_WIDTH bits).
  - 0x08 STATUS (RO): [0] BUSY, [1] DONE, [31:16] beats sent in current/last packet.
  - 0x0C SEED (RW).
  - 0x10 IDDEST (RW): TID in [7:0], TDEST in [11:8], truncated to the parameter widths.
  - 0x40 + 4k, k < NUM_DATA_REGS: DREG[k] (RW).
- Lite write:
  - Accept only when AWVALID and WVALID are both high and BVALID=0. AWREADY and WREADY pulse together for one cycle.
  - BVALID asserts the next cycle and holds until BREADY. WSTRB is applied per byte.
- Lite read: ARREADY pulses one cycle when ARVALID and RVALID=0. RVALID and RDATA follow the next cycle and hold until RREADY.
- Responses:
  - Unmapped address, or a write to STATUS: SLVERR (2'b10); reads return 0.
  - Write to LEN, MODE, SEED, IDDEST or DREG while BUSY: SLVERR, write discarded.
  - Otherwise OKAY.
- Stream FSM IDLE/RUN:
  - IDLE, START with LEN≠0: go to RUN, clear beat count, clear DONE, set BUSY. TVALID rises the cycle after START's write handshake.
  - IDLE, START with LEN=0: set DONE, emit no beats.
  - RUN: TVALID=1. TDATA/TLAST are stable until a handshake (TVALID & TREADY); each handshake increments the beat count.
  - TDATA: MODE 0 gives DREG[beat mod NUM_DATA_REGS]; MODE 1 gives SEED+beat, wrapping mod 2^32.
  - TLAST=1 on beat LEN-1, or on any beat while ABORT is pending.
  - After the TLAST handshake: with LOOP=1 and no abort, restart at beat 0 with no idle cycle. Otherwise go to IDLE, clear BUSY, set DONE.
  - TSTRB and TKEEP are always 4'hF.
- Boundary conditions:
  - START while BUSY: ignored, OKAY.
  - ABORT in IDLE: no effect.
  - ABORT latched in RUN: takes effect on the next handshake, never drops TVALID without a handshake.
  - Writing LOOP=0 during RUN is allowed and ends after the current packet.
  - Beat counter wraps at 2^LEN_WIDTH; LEN max is 2^LEN_WIDTH-1.

Decomposition:
- Package axis_lite_pattern_gen_pkg holds:
  - register offsets;
  - CTRL bit indices;
  - RESP_OKAY/RESP_SLVERR;
  - FSM state enum.
- Sub-module axis_lite_pattern_regs covers the Lite slave and register file. It exports the control/config values and a start/abort pulse, and imports BUSY/DONE/beat count.
- The stream FSM stays in the top.

Test Plan:
- Write DREG0..3 = 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 and read them back -> OKAY, identical data.
- MODE 0, LEN=6, NUM_DATA_REGS=8, START, TREADY=1 -> six beats with DREG0..5, TLAST on beat 6 only; STATUS reads 0x00060002.
- MODE 1, SEED=0xFFFFFFFE, LEN=4, TREADY toggling every cycle -> data FFFFFFFE, FFFFFFFF, 00000000, 00000001, stable while stalled.
- LOOP=1, LEN=3, MODE 1, SEED=0 -> data 0,1,2 repeating, TLAST on every 3rd beat; ABORT at beat 4 -> the next handshaked beat has TLAST, then IDLE with DONE=1.
- Write LEN during BUSY -> SLVERR, LEN unchanged. Read 0x20 -> SLVERR, rdata 0. START with LEN=0 -> DONE=1, TVALID never rises.
- Reset asserted mid-packet -> TVALID=0 next cycle; all registers read 0 after release.
